// File: rtl/cache_repl_lru_sel_if.sv
// Request-side bundle for the LRU victim selector; lock_mask exists only when CACHE_REPL_LOCK_EN is defined.
interface cache_repl_lru_sel_if #(
    parameter int WAYS = 4
);
    logic [31:0]     addr_rbuf;
    logic [WAYS-1:0] visit;
    logic            en;
    logic [WAYS-1:0] valid_mask;
    logic [WAYS-1:0] way_sel;
    logic            busy;
`ifdef CACHE_REPL_LOCK_EN
    logic [WAYS-1:0] lock_mask;

    modport master (
        output addr_rbuf, visit, en, valid_mask, lock_mask,
        input  way_sel, busy
    );
    modport slave (
        input  addr_rbuf, visit, en, valid_mask, lock_mask,
        output way_sel, busy
    );
`else
    modport master (
        output addr_rbuf, visit, en, valid_mask,
        input  way_sel, busy
    );
    modport slave (
        input  addr_rbuf, visit, en, valid_mask,
        output way_sel, busy
    );
`endif
endinterface

// File: rtl/cache_repl_lru_sel.sv
// True-LRU victim selector: per-set MRU..LRU stack, sequenced identity init after reset, invalid-way-first choice.
// Optional macro CACHE_REPL_LOCK_EN adds lock_mask; victim becomes the least-recent unlocked way.
module cache_repl_lru_sel #(
    parameter int WAYS        = 4,
    parameter int SET_BITS    = 6,
    parameter int OFFSET_BITS = 6
) (
    input  logic                 clk,
    input  logic                 rstn,
    cache_repl_lru_sel_if.slave  bus
);
    localparam int WB   = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam int SETS = 1 << SET_BITS;
    localparam int SW   = WAYS * WB;

    localparam logic [0:0] ST_INIT  = 1'b0;
    localparam logic [0:0] ST_READY = 1'b1;

    localparam logic [SET_BITS-1:0] SET_LAST = '1;

    typedef logic [SW-1:0] stack_t;

    function automatic stack_t ident_stack();
        stack_t s;
        s = '0;
        for (int k = 0; k < WAYS; k++) begin
            s[k*WB +: WB] = WB'(WAYS - 1 - k);
        end
        return s;
    endfunction

    localparam stack_t IDENT = ident_stack();

    logic [0:0]          state_q, state_d;
    logic [SET_BITS-1:0] cnt_q, cnt_d;
    stack_t              stack_q [SETS];

    logic [SET_BITS-1:0] idx;
    stack_t              cur;
    logic                busy;
    logic                unused_addr;

    assign idx  = bus.addr_rbuf[OFFSET_BITS +: SET_BITS];
    assign cur  = stack_q[idx];
    assign busy = (state_q == ST_INIT);

    assign unused_addr = ^(bus.addr_rbuf & ~(32'(SETS - 1) << OFFSET_BITS));

    // ---------------- init sequencer ----------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (state_q == ST_INIT) begin
            cnt_d = cnt_q + SET_BITS'(1);
            if (cnt_q == SET_LAST) begin
                state_d = ST_READY;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= ST_INIT;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // ---------------- recency update ----------------
    logic            vis_onehot;
    logic [WB-1:0]   vis_id;
    logic [WB-1:0]   hit_pos;
    stack_t          upd;
    logic            upd_en;

    assign vis_onehot = (bus.visit != '0) &&
                        ((bus.visit & (bus.visit - WAYS'(1))) == '0);

    always_comb begin
        vis_id = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (bus.visit[w]) begin
                vis_id = WB'(w);
            end
        end
    end

    // The stack is always a permutation of way ids, so exactly one field matches.
    always_comb begin
        hit_pos = '0;
        for (int k = 0; k < WAYS; k++) begin
            if (cur[k*WB +: WB] == vis_id) begin
                hit_pos = WB'(k);
            end
        end
    end

    always_comb begin
        upd          = cur;
        upd[WB-1:0]  = vis_id;
        for (int k = 1; k < WAYS; k++) begin
            if (WB'(k) <= hit_pos) begin
                upd[k*WB +: WB] = cur[(k-1)*WB +: WB];
            end
        end
    end

    assign upd_en = (state_q == ST_READY) && bus.en && vis_onehot;

    always_ff @(posedge clk) begin
        if (rstn) begin
            if (state_q == ST_INIT) begin
                stack_q[cnt_q] <= IDENT;
            end else if (upd_en) begin
                stack_q[idx] <= upd;
            end
        end
    end

    // ---------------- victim selection ----------------
    logic [WB-1:0]   lru_id;
    logic [WAYS-1:0] victim;

    assign lru_id = cur[(WAYS-1)*WB +: WB];

`ifdef CACHE_REPL_LOCK_EN
    logic [WAYS-1:0] cand_inv;
    logic [WB-1:0]   fid;

    assign cand_inv = ~bus.valid_mask & ~bus.lock_mask;

    always_comb begin
        victim         = '0;
        victim[lru_id] = 1'b1;
        fid            = '0;
        // Walking MRU->LRU lets the least-recent unlocked way overwrite the rest.
        for (int k = 0; k < WAYS; k++) begin
            fid = cur[k*WB +: WB];
            if (!bus.lock_mask[fid]) begin
                victim      = '0;
                victim[fid] = 1'b1;
            end
        end
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (cand_inv[w]) begin
                victim    = '0;
                victim[w] = 1'b1;
            end
        end
    end
`else
    logic [WAYS-1:0] cand_inv;

    assign cand_inv = ~bus.valid_mask;

    always_comb begin
        victim         = '0;
        victim[lru_id] = 1'b1;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (cand_inv[w]) begin
                victim    = '0;
                victim[w] = 1'b1;
            end
        end
    end
`endif

    assign bus.way_sel = busy ? '0 : victim;
    assign bus.busy    = busy;

endmodule

// File: tb/tb_cache_repl_lru_sel.sv
// Directed + randomized bench for cache_repl_lru_sel against a timestamp-based LRU model.
module tb_cache_repl_lru_sel;
    localparam int WAYS        = 4;
    localparam int SET_BITS    = 6;
    localparam int OFFSET_BITS = 6;
    localparam int SETS        = 1 << SET_BITS;
    localparam logic [WAYS-1:0] ALLV = '1;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    cache_repl_lru_sel_if #(.WAYS(WAYS)) bus();

    cache_repl_lru_sel #(
        .WAYS(WAYS), .SET_BITS(SET_BITS), .OFFSET_BITS(OFFSET_BITS)
    ) dut (
        .clk(clk),
        .rstn(rstn),
        .bus(bus)
    );

    logic [WAYS-1:0] lock_v;
`ifdef CACHE_REPL_LOCK_EN
    assign bus.lock_mask = lock_v;
`endif

    int checks = 0;
    int errors = 0;

    // Model: a way's recency is the time it was last touched; the LRU way has the oldest stamp.
    int unsigned last_use [SETS][WAYS];
    int unsigned now;

    function automatic void model_init();
        for (int s = 0; s < SETS; s++)
            for (int w = 0; w < WAYS; w++)
                last_use[s][w] = w;
        now = WAYS;
    endfunction

    function automatic void model_touch(int s, logic [WAYS-1:0] v);
        now++;
        for (int w = 0; w < WAYS; w++)
            if (v[w]) last_use[s][w] = now;
    endfunction

    function automatic logic [WAYS-1:0] model_victim(int s, logic [WAYS-1:0] vm, logic [WAYS-1:0] lk);
        logic [WAYS-1:0] r;
        int best;
        r = '0;
        best = -1;
        for (int w = 0; w < WAYS; w++) begin
            if (!vm[w] && !lk[w]) begin
                r[w] = 1'b1;
                return r;
            end
        end
        for (int w = 0; w < WAYS; w++)
            if (!lk[w] && (best < 0 || last_use[s][w] < last_use[s][best])) best = w;
        if (best < 0)
            for (int w = 0; w < WAYS; w++)
                if (best < 0 || last_use[s][w] < last_use[s][best]) best = w;
        r[best] = 1'b1;
        return r;
    endfunction

    function automatic logic [31:0] mk_addr(int s);
        return ($urandom & ~(32'(SETS - 1) << OFFSET_BITS)) | (32'(s) << OFFSET_BITS);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int s, input logic [WAYS-1:0] v, input logic e,
                         input logic [WAYS-1:0] vm, input logic [WAYS-1:0] lk);
        bus.addr_rbuf  = mk_addr(s);
        bus.visit      = v;
        bus.en         = e;
        bus.valid_mask = vm;
        lock_v         = lk;
    endtask

    task automatic cyc(input int s, input logic [WAYS-1:0] v, input logic e,
                       input logic [WAYS-1:0] vm, input logic [WAYS-1:0] lk);
        @(negedge clk);
        drive(s, v, e, vm, lk);
        #1;
        chk("way_sel_model", 32'(bus.way_sel), 32'(model_victim(s, vm, lk)));
        chk("busy_ready", 32'(bus.busy), 32'd0);
        @(posedge clk);
        if (e && $countones(v) == 1) model_touch(s, v);
    endtask

    task automatic peek(input int s, input logic [WAYS-1:0] vm, input logic [WAYS-1:0] lk,
                        input logic [WAYS-1:0] exp, input string tag);
        @(negedge clk);
        drive(s, '0, 1'b0, vm, lk);
        #1;
        chk(tag, 32'(bus.way_sel), 32'(exp));
    endtask

    // Entered just after the reset edge with rstn released; counts busy cycles.
    task automatic wait_init(input string tag);
        int n;
        logic sel_zero;
        n = 0;
        sel_zero = 1'b1;
        while (bus.busy === 1'b1 && n < 300) begin
            if (bus.way_sel !== '0) sel_zero = 1'b0;
            n++;
            @(negedge clk);
            #1;
        end
        bus.en = 1'b0;
        chk(tag, 32'(n), 32'(SETS));
        chk("way_sel_zero_while_busy", 32'(sel_zero), 32'd1);
        model_init();
    endtask

    initial begin
        int s;
        logic [WAYS-1:0] v, vm, lk;
        logic e;

        drive(5, 4'b0001, 1'b1, '0, '0);
        rstn = 1'b0;

        // 1 + 4: reset, busy length, en ignored during INIT
        @(negedge clk);
        rstn = 1'b1;
        #1;
        chk("busy_after_reset", 32'(bus.busy), 32'd1);
        wait_init("init_len");
        peek(5, ALLV, '0, 4'b0001, "identity_lru_way0");

        // 2: consecutive updates on one set
        cyc(5, 4'b0001, 1'b1, ALLV, '0);
        cyc(5, 4'b0010, 1'b1, ALLV, '0);
        cyc(5, 4'b0100, 1'b1, ALLV, '0);
        peek(5, ALLV, '0, 4'b1000, "lru_after_three");
        cyc(5, 4'b1000, 1'b1, ALLV, '0);
        peek(5, ALLV, '0, 4'b0001, "lru_wraps_way0");

        // 3: invalid-way preference
        peek(5, 4'b1011, '0, 4'b0100, "invalid_way2");
        peek(5, 4'b0000, '0, 4'b0001, "all_invalid");

        // 4: rejected updates
        cyc(5, 4'b0011, 1'b1, ALLV, '0);
        cyc(5, 4'b0000, 1'b1, ALLV, '0);
        peek(5, ALLV, '0, 4'b0001, "multihot_ignored");

        // 5: reset in the middle of INIT
        cyc(5, 4'b0001, 1'b1, ALLV, '0);
        peek(5, ALLV, '0, 4'b0010, "set5_modified");
        @(negedge clk);
        rstn = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        #1;
        wait_init("init_len_first");
        @(negedge clk);
        rstn = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        repeat (30) @(negedge clk);
        #1;
        chk("busy_at_cnt30", 32'(bus.busy), 32'd1);
        rstn = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        #1;
        wait_init("init_len_restart");
        peek(5, ALLV, '0, 4'b0001, "set5_identity_again");

`ifdef CACHE_REPL_LOCK_EN
        // 6: lock-aware selection on a fresh identity stack
        peek(5, ALLV, 4'b0001, 4'b0010, "lock_skip_way0");
        peek(5, ALLV, 4'b1111, 4'b0001, "lock_all_fallback");
        peek(5, 4'b1110, 4'b0001, 4'b0010, "locked_invalid_skipped");
`endif

        // randomized traffic checked every cycle against the model
        for (int i = 0; i < 600; i++) begin
            s  = ($urandom_range(0, 1) == 1) ? $urandom_range(4, 7) : $urandom_range(0, SETS - 1);
            if ($urandom_range(0, 9) < 7) begin
                v = '0;
                v[$urandom_range(0, WAYS - 1)] = 1'b1;
            end else begin
                v = WAYS'($urandom);
            end
            e  = ($urandom_range(0, 3) != 0);
            vm = ($urandom_range(0, 3) == 0) ? WAYS'($urandom) : ALLV;
`ifdef CACHE_REPL_LOCK_EN
            lk = ($urandom_range(0, 1) == 1) ? WAYS'($urandom) : '0;
`else
            lk = '0;
`endif
            cyc(s, v, e, vm, lk);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
